// File: rtl/fifo_pkg.sv
// fifo_pkg: shared definitions for the sync FIFO and its read-side stream adapter
package fifo_pkg;

    localparam int XFER_W = 16;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } rd_state_e;

endpackage

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: turns a show-ahead FIFO read port into a registered valid/ready stream via a 2-entry skid buffer
module fifo_rd_stream
    import fifo_pkg::*;
#(
    parameter type T = logic [7:0]
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                fifo_empty,
    input  T                    fifo_data,
    output logic                fifo_ren,
    input  logic                flush,
    output logic                m_valid,
    input  logic                m_ready,
    output T                    m_data,
    output logic [1:0]          occupancy,
    output logic [XFER_W-1:0]   xfer_cnt
);

    rd_state_e         state_q, state_d;
    T                  head_q, head_d;
    T                  skid_q, skid_d;
    logic [XFER_W-1:0] xfer_cnt_q, xfer_cnt_d;
    logic              hs;

    assign fifo_ren  = !rst && !fifo_empty && !flush && (state_q != S_TWO);
    assign m_valid   = (state_q != S_EMPTY);
    assign m_data    = head_q;
    assign occupancy = state_q;
    assign xfer_cnt  = xfer_cnt_q;

    // next-state: pop into head when it is free or draining, spill into skid when it is stalled
    always_comb begin
        hs         = m_valid && m_ready;
        state_d    = state_q;
        head_d     = head_q;
        skid_d     = skid_q;
        xfer_cnt_d = xfer_cnt_q + XFER_W'(hs);
        case (state_q)
            S_EMPTY: begin
                if (fifo_ren) begin
                    state_d = S_ONE;
                    head_d  = fifo_data;
                end
            end
            S_ONE: begin
                if (fifo_ren && hs) begin
                    head_d = fifo_data;
                end else if (fifo_ren) begin
                    state_d = S_TWO;
                    skid_d  = fifo_data;
                end else if (hs) begin
                    state_d = S_EMPTY;
                end
            end
            S_TWO: begin
                if (hs) begin
                    state_d = S_ONE;
                    head_d  = skid_q;
                end
            end
            default: state_d = S_EMPTY;
        endcase
        state_d = flush ? S_EMPTY : state_d;
    end

    // state and counter reset; payload registers carry no reset since they are ignored while empty
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_EMPTY;
            xfer_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            xfer_cnt_q <= xfer_cnt_d;
        end
        head_q <= head_d;
        skid_q <= skid_d;
    end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: directed and random checks of fifo_rd_stream against a FIFO model and beat scoreboard
module tb_fifo_rd_stream;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fifo_empty = 1'b1;
    logic [7:0]  fifo_data = 8'h00;
    logic        fifo_ren;
    logic        flush = 1'b0;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [7:0]  m_data;
    logic [1:0]  occupancy;
    logic [15:0] xfer_cnt;

    int          n_tests = 0;
    int          n_fail = 0;
    int          hs_seen = 0;
    int          base = 0;
    int          pushed = 0;
    logic [7:0]  fq[$];
    logic [7:0]  sb[$];
    logic [15:0] exp_cnt = '0;
    logic [7:0]  prev_data = '0;
    logic [7:0]  exp_beat;
    bit          pop_pend = 0;
    bit          started = 0;
    bit          prev_stall = 0;
    bit          mon_hs = 0;
    bit          mid_done = 0;

    fifo_rd_stream dut (
        .clk       (clk),
        .rst       (rst),
        .fifo_empty(fifo_empty),
        .fifo_data (fifo_data),
        .fifo_ren  (fifo_ren),
        .flush     (flush),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .occupancy (occupancy),
        .xfer_cnt  (xfer_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void refresh();
        fifo_empty = (fq.size() == 0);
        fifo_data  = (fq.size() != 0) ? fq[0] : 8'h00;
    endfunction

    task automatic push(input logic [7:0] d);
        fq.push_back(d);
        sb.push_back(d);
        refresh();
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // FIFO model: apply the pop decided at the preceding falling edge just after the rising edge
    always @(posedge clk) begin
        started <= 1'b1;
        #1;
        if (pop_pend && fq.size() != 0) begin
            void'(fq.pop_front());
            refresh();
        end
        pop_pend = 1'b0;
    end

    // monitor: scoreboard beats, read-enable rule, stall stability and handshake count
    always @(negedge clk) begin
        if (started) begin
            mon_hs = m_valid && m_ready && !rst;
            chk("xfer_cnt", 32'(xfer_cnt), 32'(exp_cnt));
            chk("fifo_ren", 32'(fifo_ren), 32'(!fifo_empty && !flush && !rst && occupancy != 2'd2));
            if (fifo_ren) chk("read_while_empty", 32'(fifo_empty), 32'(0));
            if (prev_stall && m_valid) chk("stall_stable", 32'(m_data), 32'(prev_data));
            if (mon_hs) begin
                exp_beat = 'x;
                if (sb.size() != 0) exp_beat = sb.pop_front();
                chk("beat", 32'(m_data), 32'(exp_beat));
                hs_seen++;
            end
            if (rst || flush) begin
                repeat (int'(occupancy) - int'(mon_hs)) begin
                    if (sb.size() != 0) void'(sb.pop_front());
                end
            end
            pop_pend   = fifo_ren;
            exp_cnt    = rst ? 16'h0000 : exp_cnt + 16'(mon_hs);
            prev_stall = m_valid && !m_ready && !rst && !flush;
            prev_data  = m_data;
        end
    end

    initial begin
        logic [7:0] seq[4];
        int k;
        seq = '{8'h11, 8'h22, 8'h33, 8'h44};

        // reset state
        repeat (2) cyc();
        @(negedge clk);
        chk("rst_valid", 32'(m_valid), 32'(0));
        chk("rst_occ", 32'(occupancy), 32'(0));
        chk("rst_xfer", 32'(xfer_cnt), 32'(0));
        chk("rst_ren", 32'(fifo_ren), 32'(0));

        // streaming at one beat per cycle
        cyc();
        rst = 1'b0;
        m_ready = 1'b1;
        foreach (seq[i]) push(seq[i]);
        @(negedge clk);
        chk("t1_latency", 32'(m_valid), 32'(0));
        foreach (seq[i]) begin
            @(negedge clk);
            chk("t1_valid", 32'(m_valid), 32'(1));
            chk("t1_data", 32'(m_data), 32'(seq[i]));
        end
        @(negedge clk);
        chk("t1_idle", 32'(m_valid), 32'(0));
        chk("t1_xfer", 32'(xfer_cnt), 32'(4));

        // backpressure fills both entries and holds the head
        cyc();
        m_ready = 1'b0;
        for (int i = 0; i < 3; i++) push(seq[i]);
        repeat (5) @(negedge clk);
        chk("t2_occ", 32'(occupancy), 32'(2));
        chk("t2_ren", 32'(fifo_ren), 32'(0));
        chk("t2_data", 32'(m_data), 32'(8'h11));
        cyc();
        m_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t2_order", 32'(m_data), 32'(seq[i]));
        end
        @(negedge clk);
        chk("t2_idle", 32'(m_valid), 32'(0));

        // alternating ready with random beats
        cyc();
        for (int i = 0; i < 200; i++) push(8'($urandom));
        k = 0;
        while (sb.size() != 0 && k < 2000) begin
            cyc();
            m_ready = ~m_ready;
            k++;
        end
        chk("t3_drained", 32'(sb.size()), 32'(0));

        // flush while holding two beats
        cyc();
        m_ready = 1'b0;
        for (int i = 0; i < 3; i++) push(seq[i]);
        repeat (3) cyc();
        flush = 1'b1;
        @(negedge clk);
        chk("t4_occ_pre", 32'(occupancy), 32'(2));
        chk("t4_ren", 32'(fifo_ren), 32'(0));
        cyc();
        flush = 1'b0;
        push(8'h55);
        push(8'h66);
        m_ready = 1'b1;
        @(negedge clk);
        chk("t4_occ", 32'(occupancy), 32'(0));
        chk("t4_valid", 32'(m_valid), 32'(0));
        @(negedge clk);
        chk("t4_resume", 32'(m_data), 32'(8'h33));
        k = 0;
        while (sb.size() != 0 && k < 50) begin
            cyc();
            k++;
        end
        chk("t4_drained", 32'(sb.size()), 32'(0));

        // reset after two handshakes mid-stream
        cyc();
        base = hs_seen;
        for (int i = 0; i < 4; i++) push(8'hA1 + 8'(i));
        k = 0;
        while (hs_seen < base + 2 && k < 20) begin
            cyc();
            k++;
        end
        chk("t5_two_hs", 32'(hs_seen - base), 32'(2));
        rst = 1'b1;
        m_ready = 1'b0;
        cyc();
        @(negedge clk);
        chk("t5_valid", 32'(m_valid), 32'(0));
        chk("t5_occ", 32'(occupancy), 32'(0));
        chk("t5_xfer", 32'(xfer_cnt), 32'(0));
        chk("t5_ren", 32'(fifo_ren), 32'(0));
        cyc();
        rst = 1'b0;
        m_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("t5_next", 32'(m_data), 32'(8'hA4));
        k = 0;
        while (sb.size() != 0 && k < 20) begin
            cyc();
            k++;
        end
        chk("t5_drained", 32'(sb.size()), 32'(0));

        // counter wrap after 0x10000 handshakes
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        m_ready = 1'b1;
        base = hs_seen;
        pushed = 0;
        k = 0;
        while ((pushed < 65536 || sb.size() != 0) && k < 70000) begin
            if (pushed < 65536) begin
                push(8'($urandom));
                pushed++;
            end
            cyc();
            k++;
            if (!mid_done && hs_seen - base == 65534) begin
                mid_done = 1;
                chk("t6_fffe", 32'(xfer_cnt), 32'(16'hFFFE));
            end
        end
        chk("t6_drained", 32'(sb.size()), 32'(0));
        chk("t6_wrap", 32'(xfer_cnt), 32'(16'h0000));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_rd_stream.md
FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

Interface
REQ-001 The module SHALL have one parameter: T, type, default logic [7:0], the payload type; it matches the T of the attached sync FIFO.
REQ-002 clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 fifo_empty  input  1  FIFO empty flag.
REQ-005 fifo_data  input  T  FIFO show-ahead head entry; valid whenever fifo_empty=0.
REQ-006 fifo_ren  output  1  FIFO read enable; pops the head at the rising edge where it is 1.
REQ-007 flush  input  1  discard all buffered beats.
REQ-008 m_valid  output  1  output stream beat valid.
REQ-009 m_ready  input  1  downstream accepts beat.
REQ-010 m_data  output  T  output stream payload.
REQ-011 occupancy  output  2  buffered beats, 0..2.
REQ-012 xfer_cnt  output  16  count of completed output handshakes.

Function
REQ-013 The block SHALL implement a 2-entry skid buffer with states S_EMPTY, S_ONE and S_TWO; occupancy SHALL equal 0, 1 or 2 respectively.
REQ-014 fifo_ren SHALL be !fifo_empty & !flush & (state!=S_TWO), and SHALL NOT depend combinationally on m_ready.
REQ-015 m_valid SHALL be (state!=S_EMPTY) and m_data SHALL be the head register; both SHALL be driven from registers only.
REQ-016 A handshake is m_valid & m_ready; rd = fifo_ren.
REQ-017 From S_EMPTY: rd -> S_ONE with head<=fifo_data; else stay.
REQ-018 From S_ONE: rd & handshake -> S_ONE with head<=fifo_data; rd & !handshake -> S_TWO with skid<=fifo_data; !rd & handshake -> S_EMPTY; else hold.
REQ-019 From S_TWO: handshake -> S_ONE with head<=skid; else hold with data stable.
REQ-020 Latency SHALL be one cycle: a FIFO pop at edge N SHALL give m_valid=1 with that data in the cycle after edge N.
REQ-021 With fifo_empty=0 and m_ready=1 continuously, the block SHALL sustain one beat per cycle.
REQ-022 Beat order SHALL be preserved, with no loss and no duplication, for any m_ready pattern.
REQ-023 While m_valid=1 and m_ready=0, m_data SHALL NOT change.
REQ-024 flush SHALL have priority: the next state SHALL be S_EMPTY and fifo_ren SHALL be 0 that cycle. A handshake in the flush cycle SHALL still count in xfer_cnt.
REQ-025 xfer_cnt SHALL increment by 1 per handshake and wrap from 0xFFFF to 0x0000.

Reset
REQ-026 While rst=1 the block SHALL enter S_EMPTY: m_valid=0, occupancy=0, xfer_cnt=0, fifo_ren=0. The head and skid registers are don't-care.
REQ-027 Reset asserted mid-transfer SHALL discard buffered beats. Beats already popped from the FIFO are lost by design.
REQ-028 rst SHALL override flush and all handshakes.

Structure
REQ-029 The state enum rd_state_e (S_EMPTY, S_ONE, S_TWO) SHALL reside in the shared package fifo_pkg alongside the FIFO's common definitions.
REQ-030 The block SHALL be a single module; no sub-module is natural at this size.

Verification
REQ-031 Streaming: FIFO holds 0x11,0x22,0x33,0x44 and m_ready=1 -> m_data is 0x11..0x44 on 4 consecutive cycles and xfer_cnt=4.
REQ-032 Backpressure: 3 entries and m_ready=0 for 5 cycles -> occupancy=2, fifo_ren=0, m_data=0x11 stable; on m_ready=1, order is preserved.
REQ-033 Alternating m_ready (1,0,1,0...) with 200 random beats -> scoreboard queue matches every beat and the FIFO is never read while empty.
REQ-034 Flush in S_TWO -> next cycle occupancy=0, m_valid=0, fifo_ren=0 in the flush cycle; subsequent beats resume in order.
REQ-035 Reset mid-stream after 2 handshakes -> all outputs at reset values in the following cycle, xfer_cnt=0.
REQ-036 Wrap: preload xfer_cnt at 0xFFFE by 0xFFFE handshakes, then 2 more -> xfer_cnt=0x0000.
